// File: rtl/phase_freq_detector.sv
// Sampled PFD: synchronises ref/fb, times the lead between rising edges; lock detect built only with PFD_LOCK_DETECT_EN.
// Latency: closing edge seen in cycle N -> up_out/down_out and err_mag in cycle N+1; locked settles in that same cycle.
// Backpressure: none, pulses are fire-and-forget one-cycle strobes into the up/down counter.
module phase_freq_detector #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 64,
    parameter int LOCK_TOL    = 1
) (
    input  logic       clkUD,
    input  logic       reset_n,
    input  logic       ref_in,
    input  logic       fb_in,
    input  logic       enable,
    output logic       up_out,
    output logic       down_out,
    output logic [7:0] err_mag,
    output logic       locked
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        FB_LEAD  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] ref_sync;
    logic [SYNC_STAGES-1:0] fb_sync;
    logic                   ref_prev;
    logic                   fb_prev;
    logic                   ref_rise;
    logic                   fb_rise;
    logic [7:0]             cnt;
    logic [7:0]             cnt_nxt;
    logic [7:0]             cnt_inc;
    logic [7:0]             err_nxt;
    logic                   up_nxt;
    logic                   down_nxt;

    // Synchronisers ignore enable so re-enabling never exposes a stale edge.
    always_ff @(posedge clkUD or negedge reset_n) begin
        if (!reset_n) begin
            ref_sync <= '0;
            fb_sync  <= '0;
            ref_prev <= 1'b0;
            fb_prev  <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
            fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_in};
            ref_prev <= ref_sync[SYNC_STAGES-1];
            fb_prev  <= fb_sync[SYNC_STAGES-1];
        end
    end

    assign ref_rise = ref_sync[SYNC_STAGES-1] & ~ref_prev;
    assign fb_rise  = fb_sync[SYNC_STAGES-1] & ~fb_prev;
    assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_mag;
        up_nxt    = 1'b0;
        down_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (ref_rise && fb_rise) begin
                    err_nxt = '0;
                end else if (ref_rise) begin
                    state_nxt = REF_LEAD;
                    cnt_nxt   = '0;
                end else if (fb_rise) begin
                    state_nxt = FB_LEAD;
                    cnt_nxt   = '0;
                end
            end
            REF_LEAD: begin
                cnt_nxt = cnt_inc;
                if (ref_rise || fb_rise) begin
                    up_nxt  = 1'b1;
                    err_nxt = cnt_inc;
                    // A fresh reference edge opens the next interval immediately.
                    if (ref_rise) cnt_nxt = '0;
                    else          state_nxt = IDLE;
                end
            end
            FB_LEAD: begin
                cnt_nxt = cnt_inc;
                if (ref_rise || fb_rise) begin
                    down_nxt = 1'b1;
                    err_nxt  = cnt_inc;
                    if (fb_rise) cnt_nxt = '0;
                    else         state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            err_nxt   = '0;
            up_nxt    = 1'b0;
            down_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clkUD or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            err_mag  <= '0;
            up_out   <= 1'b0;
            down_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            err_mag  <= err_nxt;
            up_out   <= up_nxt;
            down_out <= down_nxt;
        end
    end

`ifdef PFD_LOCK_DETECT_EN
    localparam int LW = $clog2(LOCK_COUNT + 1);

    logic [LW-1:0] lock_cnt;
    logic          cmp_vld;
    logic          freq_err;
    logic          cmp_ok;

    // A second leading edge before the lagging one is a frequency error, never in tolerance.
    assign cmp_vld  = (state == IDLE) ? (ref_rise & fb_rise) : (ref_rise | fb_rise);
    assign freq_err = ((state == REF_LEAD) && ref_rise && !fb_rise) ||
                      ((state == FB_LEAD)  && fb_rise  && !ref_rise);
    assign cmp_ok   = !freq_err && (int'(err_nxt) <= LOCK_TOL);

    always_ff @(posedge clkUD or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (!enable) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (cmp_vld) begin
            if (cmp_ok) begin
                if (lock_cnt != LW'(LOCK_COUNT)) lock_cnt <= lock_cnt + LW'(1);
                if (lock_cnt >= LW'(LOCK_COUNT - 1)) locked <= 1'b1;
            end else begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_phase_freq_detector.sv
// Randomised and directed stimulus for phase_freq_detector, checked every cycle against a timestamp-based model.
// Lock expectations follow PFD_LOCK_DETECT_EN; without it locked must stay low.
module tb_phase_freq_detector;

    localparam int S    = 2;
    localparam int LC   = 4;
    localparam int TOL  = 1;
    localparam int HMAX = 32768;
`ifdef PFD_LOCK_DETECT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clkUD   = 1'b0;
    logic       reset_n = 1'b1;
    logic       ref_in  = 1'b0;
    logic       fb_in   = 1'b0;
    logic       enable  = 1'b0;
    logic       up_out;
    logic       down_out;
    logic [7:0] err_mag;
    logic       locked;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit hist_ref [HMAX];
    bit hist_fb  [HMAX];

    // Model state: which side leads, when its edge was seen, last error and lock run length.
    int m_state = 0;
    int m_open  = 0;
    int m_err   = 0;
    int m_lc    = 0;
    bit m_up    = 1'b0;
    bit m_down  = 1'b0;
    bit m_locked = 1'b0;

    int n_up, n_down, last_up_err, last_down_err;

    phase_freq_detector #(
        .SYNC_STAGES(S),
        .LOCK_COUNT (LC),
        .LOCK_TOL   (TOL)
    ) dut (
        .clkUD   (clkUD),
        .reset_n (reset_n),
        .ref_in  (ref_in),
        .fb_in   (fb_in),
        .enable  (enable),
        .up_out  (up_out),
        .down_out(down_out),
        .err_mag (err_mag),
        .locked  (locked)
    );

    always #5 clkUD = ~clkUD;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic bit href(input int i);
        return (i < 0) ? 1'b0 : hist_ref[i];
    endfunction

    function automatic bit hfb(input int i);
        return (i < 0) ? 1'b0 : hist_fb[i];
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_err    = 0;
        m_lc     = 0;
        m_up     = 1'b0;
        m_down   = 1'b0;
        m_locked = 1'b0;
    endtask

    // An input level first sampled at edge m shows up as a detected rise acted upon at edge m+S.
    task automatic model_step(input bit en);
        bit rr, fr, cmp, bad;
        rr = href(cyc - S) && !href(cyc - S - 1);
        fr = hfb(cyc - S)  && !hfb(cyc - S - 1);
        m_up   = 1'b0;
        m_down = 1'b0;
        cmp    = 1'b0;
        bad    = 1'b0;
        if (!en) begin
            m_state  = 0;
            m_err    = 0;
            m_lc     = 0;
            m_locked = 1'b0;
            return;
        end
        case (m_state)
            0: begin
                if (rr && fr) begin
                    m_err = 0;
                    cmp   = 1'b1;
                end else if (rr) begin
                    m_state = 1;
                    m_open  = cyc;
                end else if (fr) begin
                    m_state = 2;
                    m_open  = cyc;
                end
            end
            default: begin
                if (rr || fr) begin
                    m_err = (cyc - m_open > 255) ? 255 : cyc - m_open;
                    cmp   = 1'b1;
                    if (m_state == 1) begin
                        m_up = 1'b1;
                        bad  = rr && !fr;
                        if (rr) m_open = cyc;
                        else    m_state = 0;
                    end else begin
                        m_down = 1'b1;
                        bad    = fr && !rr;
                        if (fr) m_open = cyc;
                        else    m_state = 0;
                    end
                end
            end
        endcase
        if (cmp) begin
            if (!bad && m_err <= TOL) begin
                if (m_lc < LC) m_lc++;
                if (m_lc == LC) m_locked = 1'b1;
            end else begin
                m_lc     = 0;
                m_locked = 1'b0;
            end
        end
    endtask

    task automatic step(input bit r, input bit f, input bit en);
        if (cyc + 1 >= HMAX) begin
            $display("FAIL history_bound: got %0d, expected below %0d", cyc + 1, HMAX);
            $fatal(1, "history overflow");
        end
        ref_in = r;
        fb_in  = f;
        enable = en;
        hist_ref[cyc + 1] = r;
        hist_fb[cyc + 1]  = f;
        @(posedge clkUD);
        cyc++;
        #1;
        model_step(en);
        check("up_out",   up_out,   m_up);
        check("down_out", down_out, m_down);
        check("err_mag",  err_mag,  m_err);
        check("locked",   locked,   LOCK_EN ? m_locked : 1'b0);
        if (up_out) begin
            n_up++;
            last_up_err = err_mag;
        end
        if (down_out) begin
            n_down++;
            last_down_err = err_mag;
        end
    endtask

    task automatic wave(input int ncyc, input int rp, input int roff, input int fp, input int foff);
        for (int t = 0; t < ncyc; t++)
            step(((t + rp - roff) % rp) < rp / 2, ((t + fp - foff) % fp) < fp / 2, 1'b1);
    endtask

    task automatic gap();
        for (int t = 0; t < 12; t++) step(1'b0, 1'b0, !(t >= 5 && t < 8));
    endtask

    task automatic clear_stats();
        n_up = 0;
        n_down = 0;
        last_up_err = -1;
        last_down_err = -1;
    endtask

    task automatic do_reset(input int ncyc);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_up",     up_out,   0);
        check("rst_down",   down_out, 0);
        check("rst_err",    err_mag,  0);
        check("rst_locked", locked,   0);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clkUD);
            cyc++;
            hist_ref[cyc] = 1'b0;
            hist_fb[cyc]  = 1'b0;
            #1;
        end
        reset_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset(3);
        gap();

        // Reference leads by 5 cycles.
        clear_stats();
        wave(100, 20, 0, 20, 5);
        gap();
        check("lead5_nup",   n_up, 5);
        check("lead5_ndown", n_down, 0);
        check("lead5_err",   last_up_err, 5);

        // Feedback leads by 3 cycles.
        clear_stats();
        wave(100, 20, 3, 20, 0);
        gap();
        check("fb3_ndown", n_down, 5);
        check("fb3_nup",   n_up, 0);
        check("fb3_err",   last_down_err, 3);

        // Aligned edges build lock, then a 6-cycle lead breaks it.
        clear_stats();
        wave(80, 16, 0, 16, 0);
        check("align_npulse", n_up + n_down, 0);
        check("align_err",    err_mag, 0);
        check("align_locked", locked, LOCK_EN);
        wave(16, 16, 0, 16, 6);
        check("lead6_nup",    n_up, 1);
        check("lead6_err",    last_up_err, 6);
        check("lead6_locked", locked, 0);
        gap();

        // Reference at twice the feedback frequency.
        clear_stats();
        wave(80, 10, 0, 20, 0);
        check("freq_nup",   n_up, 6);
        check("freq_ndown", n_down, 0);
        check("freq_err",   last_up_err, 10);
        gap();

        // Feedback silent for 300 cycles after a reference edge.
        clear_stats();
        for (int t = 0; t < 5; t++)   step(1'b1, 1'b0, 1'b1);
        for (int t = 0; t < 300; t++) step(1'b0, 1'b0, 1'b1);
        check("sat_nup_before", n_up, 0);
        for (int t = 0; t < 5; t++)   step(1'b0, 1'b1, 1'b1);
        for (int t = 0; t < 5; t++)   step(1'b0, 1'b0, 1'b1);
        check("sat_nup", n_up, 1);
        check("sat_err", last_up_err, 255);
        gap();

        // Enable dropped while the reference leads.
        clear_stats();
        for (int t = 0; t < 5; t++) step(1'b1, 1'b0, 1'b1);
        for (int t = 0; t < 2; t++) step(1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 4; t++) step(1'b0, 1'b0, 1'b0);
        check("endrop_nup",    n_up, 0);
        check("endrop_err",    err_mag, 0);
        check("endrop_locked", locked, 0);
        for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 1'b1);
        wave(16, 16, 0, 16, 4);
        check("reen_nup",   n_up, 1);
        check("reen_ndown", n_down, 0);
        check("reen_err",   last_up_err, 4);

        // Reset asserted while locked and with the reference leading.
        wave(80, 16, 0, 16, 0);
        check("prerst_locked", locked, LOCK_EN);
        clear_stats();
        for (int t = 0; t < 5; t++) step(1'b1, 1'b0, 1'b1);
        for (int t = 0; t < 2; t++) step(1'b0, 1'b0, 1'b1);
        do_reset(3);
        for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 1'b1);
        check("rstmid_nup", n_up, 0);
        wave(16, 16, 0, 16, 4);
        check("rstmid_first_nup", n_up, 1);
        check("rstmid_first_err", last_up_err, 4);

        // Random periods, phases and frequency ratios.
        for (int i = 0; i < 25; i++) begin
            int p, fp, foff, sel;
            p   = $urandom_range(8, 32);
            sel = $urandom_range(0, 2);
            fp  = (sel == 0) ? p : (sel == 1) ? 2 * p : p + $urandom_range(1, 3);
            foff = $urandom_range(0, fp - 1);
            wave(3 * fp, p, 0, fp, foff);
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 1'b0, 1'b0);
                step(1'b0, 1'b0, 1'b0);
            end
        end
        gap();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
